// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;

   // widest register number an entry can hold
   localparam int SB_AW = 8;

   typedef struct packed {
      logic             valid;
      logic             wen;
      logic [SB_AW-1:0] wn;
      logic             load;
      logic [SB_AW-1:0] rs;
      logic [SB_AW-1:0] rt;
      logic             use_rs;
      logic             use_rt;
   } sb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, redirect flush, EX forwarding and ID write-back bypass
// driven from a shadow scoreboard of the EX/MEM/WB destinations.
module pipe_hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int BR_STAGE   = 3,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wen,
   input  logic [REG_AW-1:0] id_wn,
   input  logic              id_load,
   input  logic              redirect,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              id_byp_rs,
   output logic              id_byp_rt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   if (!(LOAD_STALL == 1 || LOAD_STALL == 2) ||
       !(BR_STAGE == STG_EX || BR_STAGE == STG_MEM) ||
       (REG_AW > SB_AW) || (REG_AW < 1)) begin : g_bad_param
      $error("pipe_hazard_unit: illegal parameter set");
   end

   localparam int EXI = 0;
   localparam int MEI = 1;
   localparam int WBI = 2;

   sb_entry_t r_sb [3];
   sb_entry_t w_id;
   sb_entry_t w_nx_ex;
   sb_entry_t w_nx_mem;

   logic [SB_AW-1:0] w_rs;
   logic [SB_AW-1:0] w_rt;
   logic             w_redir;
   logic             w_ld_ex;
   logic             w_ld_mem;
   logic             w_stall;

   function automatic logic hit(sb_entry_t e, logic [SB_AW-1:0] r);
      return e.valid & e.wen & (e.wn == r) & (r != '0);
   endfunction

   function automatic logic ld_hit(sb_entry_t e, logic ua, logic [SB_AW-1:0] ra,
                                   logic ub, logic [SB_AW-1:0] rb);
      return e.load & ((ua & hit(e, ra)) | (ub & hit(e, rb)));
   endfunction

   // youngest producer wins; a MEM load is never a forwarding source
   function automatic logic [1:0] fwd_sel(sb_entry_t m, sb_entry_t w,
                                          logic u, logic [SB_AW-1:0] r);
      if (u & hit(m, r) & ~m.load) return FWD_MEM;
      if (u & hit(w, r))           return FWD_WB;
      return FWD_RF;
   endfunction

   assign w_rs = SB_AW'(id_rs);
   assign w_rt = SB_AW'(id_rt);

   assign w_redir  = redirect & rst;
   assign w_ld_ex  = ld_hit(r_sb[EXI], id_use_rs, w_rs, id_use_rt, w_rt);
   assign w_ld_mem = ld_hit(r_sb[MEI], id_use_rs, w_rs, id_use_rt, w_rt);
   assign w_stall  = id_valid & ~w_redir &
                     (w_ld_ex | ((LOAD_STALL == 2) & w_ld_mem));

   assign pc_en       = ~w_stall;
   assign ifid_en     = ~w_stall;
   assign ifid_flush  = w_redir;
   assign idex_flush  = w_redir | w_stall;
   assign exmem_flush = (BR_STAGE == STG_MEM) & w_redir;

   assign fwd_a = fwd_sel(r_sb[MEI], r_sb[WBI], r_sb[EXI].use_rs, r_sb[EXI].rs);
   assign fwd_b = fwd_sel(r_sb[MEI], r_sb[WBI], r_sb[EXI].use_rt, r_sb[EXI].rt);

   assign id_byp_rs = id_valid & id_use_rs & hit(r_sb[WBI], w_rs);
   assign id_byp_rt = id_valid & id_use_rt & hit(r_sb[WBI], w_rt);

   always_comb begin
      w_id        = '0;
      w_id.valid  = id_valid;
      w_id.wen    = id_wen;
      w_id.wn     = SB_AW'(id_wn);
      w_id.load   = id_load;
      w_id.rs     = w_rs;
      w_id.rt     = w_rt;
      w_id.use_rs = id_use_rs;
      w_id.use_rt = id_use_rt;
   end

   always_comb begin
      w_nx_ex = '0;
      if (!w_stall && !w_redir) w_nx_ex = w_id;
      w_nx_mem = r_sb[EXI];
      if (w_redir && (BR_STAGE == STG_MEM)) w_nx_mem = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sb[EXI] <= '0;
         r_sb[MEI] <= '0;
         r_sb[WBI] <= '0;
      end else begin
         r_sb[EXI] <= w_nx_ex;
         r_sb[MEI] <= w_nx_mem;
         r_sb[WBI] <= r_sb[MEI];
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_stall),
      .cnt (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_redir),
      .cnt (flush_cnt)
   );

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard, forwarding and flush controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow scoreboard of in-flight destination registers.
- Drives stall enables, bubble/flush controls, EX-stage forwarding selects and ID-stage write-back bypass.
- Successor to the fixed, hazard-free pipeline: adds load-use stalls, configurable branch-resolve stage, configurable load latency and stall/flush performance counters.

Parameters:
- REG_AW, 5, register-number width (register file has 2**REG_AW entries).
- BR_STAGE, 3, stage where branch/jump/jr redirects resolve: 2=EX, 3=MEM.
- LOAD_STALL, 1, load-use stall cycles: 1 or 2 (2 = data memory result only usable from WB).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  ID source register A
- id_rt  in  REG_AW  ID source register B
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wen  in  1  ID instruction writes a register
- id_wn  in  REG_AW  ID destination (after RegDst selection)
- id_load  in  1  ID instruction is a load
- redirect  in  1  branch taken / jump / jr resolved this cycle in BR_STAGE
- pc_en  out  1  PC register enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_flush  out  1  ID/EX loads a bubble
- exmem_flush  out  1  EX/MEM loads a bubble (used only when BR_STAGE=3)
- fwd_a  out  2  EX operand A select: 00 register file, 01 EX/MEM ALU result, 10 WB data
- fwd_b  out  2  EX operand B select, same encoding
- id_byp_rs  out  1  ID takes WB write data for rs
- id_byp_rt  out  1  ID takes WB write data for rt
- stall_cnt  out  CNT_W  stall cycles since reset
- flush_cnt  out  CNT_W  redirects since reset

Behaviour:
- Scoreboard entries EX, MEM and WB, each holding {valid, wen, wn, load, rs, rt, use_rs, use_rt}. All entries shift one stage per clock.
- Entry loaded into EX:
  - ID fields when ID is not stalled.
  - A bubble (valid=0) when stalled or flushed.
- hit(stage, r) = entry.valid & entry.wen & (entry.wn == r) & (r != 0). Register 0 never causes a hazard.
- Load-use stall condition (combinational):
  - id_valid and a used ID source hits EX with load=1, or
  - LOAD_STALL=2 and a used ID source hits MEM with load=1.
- Stall effect: pc_en=0, ifid_en=0, idex_flush=1. stall_cnt increments.
- Redirect effect:
  - ifid_flush=1 and idex_flush=1.
  - exmem_flush=1 when BR_STAGE=3.
  - pc_en=1, ifid_en=1.
  - Scoreboard entries younger than BR_STAGE are invalidated on the same edge.
  - flush_cnt increments.
- Redirect has priority over stall. The stalled instruction is squashed, and stall_cnt does not increment that cycle.
- Forwarding for fwd_a (and fwd_b, using rt):
  - 01 if EX's rs hits MEM and MEM.load=0.
  - Else 10 if it hits WB.
  - Else 00.
  - MEM has priority over WB, so the youngest producer wins.
  - A used source never hits a MEM load in EX; the stall guarantees this.
- id_byp_rs/rt = id_valid & use & hit(WB, src). This covers the register file's read-before-write timing.
- All outputs are combinational from the scoreboard, the ID inputs and redirect. Only the scoreboard and counters are registered.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- Reset (rst=0, at any time including mid-stall):
  - All entries invalid, counters 0.
  - Outputs: pc_en=1, ifid_en=1, all flush outputs 0, fwd 00, byp 0.
  - Recovery on the first clock edge after release.
- LOAD_STALL values other than 1/2 and BR_STAGE values other than 2/3 are illegal; elaboration fails.

Decomposition:
- Shared package pipe_pkg:
  - Forwarding encodings FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - Stage index constants STG_EX=2, STG_MEM=3.
  - Scoreboard entry struct.
- One sub-module: sat_counter (CNT_W, inc), instantiated twice.

Test Plan:
- Reset mid-stall: lw r5 in EX, consumer in ID, drop rst -> pc_en=1, idex_flush=0, fwd_a=00, both counters 0 while rst=0.
- ALU RAW: add r3 then sub r4,r3,r1 -> sub in EX gives fwd_a=01. With one instruction between -> fwd_a=10. With two between -> id_byp_rs=1 in ID.
- Load-use, LOAD_STALL=1: lw r5 then add r6,r5,r2 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then fwd_a=10, stall_cnt=1. With LOAD_STALL=2 -> two stall cycles, stall_cnt=2.
- Register 0: add r0 then add r7,r0,r0 -> no stall, fwd 00, byp 0.
- Redirect, BR_STAGE=3, asserted in the same cycle as a load-use stall -> ifid_flush=idex_flush=exmem_flush=1, pc_en=1, flush_cnt=1, stall_cnt unchanged. With BR_STAGE=2 -> exmem_flush stays 0.
- Saturation, CNT_W=4: 20 consecutive redirects -> flush_cnt holds 15.
